uart_tx_framer: RTL and testbench

Parametrised successor to the team's fixed 8N1 UART transmitter. It accepts bytes over a valid/ready stream into an internal FIFO and serialises them onto `tx`. Word length and FIFO depth are set by parameters; parity and stop-bit count are set at run time. It sits between the host-side register or stream logic and the pad. It shares the external `baud_tick` strobe from the baud generator, so several channels can run off one divider.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_sync_fifo.sv | 39 +++
 rtl/uart_tx_framer.sv | 94 +++++++++
 tb/tb_uart_tx_framer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: parity encodings and frame FSM states shared by the UART TX and RX paths
package uart_pkg;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } uart_state_e;
  function automatic logic par_enabled(input logic [1:0] mode);
    return mode == PAR_EVEN || mode == PAR_ODD;
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with occupancy count, no write-through bypass
module uart_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: FIFO-buffered UART transmitter with run-time parity and stop-bit selection
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  output logic                 tx,
  output logic                 tx_busy,
  output logic [CW-1:0]        fifo_count
);
  uart_state_e state, state_n;
  logic [DATA_BITS-1:0] shift, shift_n, head;
  logic [3:0] cnt, cnt_n;
  logic [1:0] mode_q, mode_n;
  logic stop2_q, stop2_n, par_q, par_n, tx_n, pop, done, full, empty;
  assign s_ready = !full;
  uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS), .CW(CW)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (s_valid && s_ready),
    .pop  (pop),
    .wdata(s_data),
    .rdata(head),
    .full (full),
    .empty(empty),
    .count(fifo_count)
  );
  // A frame ends either in STOP2 or in STOP1 when one stop bit was latched
  always_comb begin
    done    = state == ST_STOP2 || (state == ST_STOP1 && !stop2_q);
    pop     = baud_tick && !empty && (state == ST_IDLE || done);
    state_n = state;
    shift_n = shift;
    cnt_n   = cnt;
    mode_n  = mode_q;
    stop2_n = stop2_q;
    par_n   = par_q;
    if (pop) begin
      state_n = ST_START;
      shift_n = head;
      cnt_n   = '0;
      mode_n  = parity_mode;
      stop2_n = stop2;
      par_n   = ^head ^ (parity_mode == PAR_ODD);
    end else if (baud_tick) begin
      case (state)
        ST_START:  state_n = ST_DATA;
        ST_DATA: begin
          shift_n = shift >> 1;
          cnt_n   = cnt + 4'd1;
          if (cnt == 4'(DATA_BITS - 1)) state_n = par_enabled(mode_q) ? ST_PARITY : ST_STOP1;
        end
        ST_PARITY: state_n = ST_STOP1;
        ST_STOP1:  state_n = stop2_q ? ST_STOP2 : ST_IDLE;
        ST_STOP2:  state_n = ST_IDLE;
        default:   state_n = state;
      endcase
    end
    tx_n = state_n == ST_START ? 1'b0 :
           state_n == ST_DATA ? shift_n[0] :
           state_n == ST_PARITY ? par_n : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      shift   <= '0;
      cnt     <= '0;
      mode_q  <= PAR_NONE;
      stop2_q <= 1'b0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      cnt     <= cnt_n;
      mode_q  <= mode_n;
      stop2_q <= stop2_n;
      par_q   <= par_n;
      tx      <= tx_n;
      tx_busy <= state_n != ST_IDLE;
    end
  end
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: table vectors, corner sequences and random frames checked per baud tick
module tb_uart_tx_framer;
  import uart_pkg::*;
  localparam int DB = 8;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);
  logic clk = 0, rst = 1, baud_tick = 0, s_valid = 0, stop2 = 0;
  logic tx, tx_busy, s_ready, mon_t;
  logic [DB-1:0] s_data = '0;
  logic [1:0] parity_mode = PAR_NONE;
  logic [CW-1:0] fifo_count;
  int tests = 0, fails = 0, tick_period = 0, tcnt = 0, cyc = 0;
  typedef struct {logic tx; logic busy; logic ready; int count; int cyc;} ent_t;
  typedef struct {logic [7:0] data; logic [1:0] mode; logic s2; int len; logic [11:0] bits;} vec_t;
  ent_t mon_q[$];
  logic [1:0] exp_q[$];
  vec_t vecs[6];

  uart_tx_framer #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .parity_mode(parity_mode), .stop2(stop2), .tx(tx), .tx_busy(tx_busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (tick_period == 0) begin
      tcnt = 0;
      baud_tick = 0;
    end else begin
      tcnt++;
      baud_tick = tcnt >= tick_period;
      if (baud_tick) tcnt = 0;
    end
  end

  // one record of the line state after every edge that sampled a tick
  always @(posedge clk) begin
    mon_t = baud_tick;
    cyc++;
    #1;
    if (mon_t) mon_q.push_back('{tx, tx_busy, s_ready, int'(fifo_count), cyc});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add_frame(input logic [7:0] d, input logic [1:0] m, input logic s2);
    exp_q.push_back(2'b01);
    for (int i = 0; i < DB; i++) exp_q.push_back({d[i], 1'b1});
    if (m == PAR_EVEN) exp_q.push_back({1'($countones(d) % 2), 1'b1});
    if (m == PAR_ODD) exp_q.push_back({1'($countones(d) % 2 == 0), 1'b1});
    exp_q.push_back(2'b11);
    if (s2) exp_q.push_back(2'b11);
  endfunction

  task automatic prep();
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic push_word(input logic [7:0] d, input string name);
    int ok = 0;
    @(negedge clk);
    s_data = d;
    s_valid = 1;
    for (int n = 0; n < 200 && ok == 0; n++) begin
      if (s_ready) ok = 1;
      @(negedge clk);
    end
    s_valid = 0;
    check({name, "_accept"}, ok, 1);
  endtask

  task automatic run_and_check(input string name, input int period);
    tick_period = period;
    for (int n = 0; n < 5000 && mon_q.size() < exp_q.size(); n++) @(negedge clk);
    tick_period = 0;
    if (mon_q.size() < exp_q.size()) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d ticks expected %0d", name, mon_q.size(), exp_q.size());
    end else
      foreach (exp_q[i]) check($sformatf("%s_txbusy[%0d]", name, i), {mon_q[i].tx, mon_q[i].busy}, exp_q[i]);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    int n;
    vecs[0] = '{8'hA5, PAR_NONE, 1'b0, 10, 12'h34A};
    vecs[1] = '{8'h03, PAR_EVEN, 1'b0, 11, 12'h406};
    vecs[2] = '{8'h03, PAR_ODD,  1'b0, 11, 12'h606};
    vecs[3] = '{8'h00, PAR_NONE, 1'b1, 11, 12'h600};
    vecs[4] = '{8'h81, 2'b11,    1'b0, 10, 12'h302};
    vecs[5] = '{8'hFF, PAR_ODD,  1'b1, 12, 12'hFFE};
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_ready", s_ready, 1);
    check("reset_count", fifo_count, 0);

    foreach (vecs[v]) begin
      prep();
      parity_mode = vecs[v].mode;
      stop2 = vecs[v].s2;
      push_word(vecs[v].data, "vec");
      for (int i = 0; i < vecs[v].len; i++) exp_q.push_back({vecs[v].bits[i], 1'b1});
      exp_q.push_back(2'b10);
      run_and_check($sformatf("vec%0d", v), 4);
    end

    prep();
    parity_mode = PAR_NONE;
    stop2 = 1;
    push_word(8'h00, "toggle");
    add_frame(8'h00, PAR_NONE, 1'b1);
    exp_q.push_back(2'b10);
    tick_period = 3;
    for (int k = 0; k < 100 && mon_q.size() < 3; k++) @(negedge clk);
    stop2 = 0;
    parity_mode = PAR_EVEN;
    run_and_check("toggle", 3);
    parity_mode = PAR_NONE;

    prep();
    for (int k = 0; k < 4; k++) begin
      d = 8'(8'h11 * (k + 1));
      push_word(d, "b2b");
      add_frame(d, PAR_NONE, 1'b0);
    end
    exp_q.push_back(2'b10);
    check("full_ready", s_ready, 0);
    check("full_count", fifo_count, 4);
    s_data = 8'h55;
    s_valid = 1;
    repeat (5) @(negedge clk);
    check("stall_count", fifo_count, 4);
    check("stall_ready", s_ready, 0);
    s_valid = 0;
    run_and_check("b2b", 2);
    if (mon_q.size() >= 41) begin
      for (int f = 0; f < 4; f++) check($sformatf("b2b_count%0d", f), mon_q[10 * f].count, 3 - f);
      check("b2b_ready_after_pop", mon_q[0].ready, 1);
      check("b2b_count_end", mon_q[40].count, 0);
    end

    prep();
    for (int k = 0; k < 3; k++) push_word(8'hC3, "rstq");
    tick_period = 4;
    for (int k = 0; k < 200 && mon_q.size() < 5; k++) @(negedge clk);
    check("rst_reached_bit3", mon_q.size() >= 5, 1);
    rst = 1;
    tick_period = 0;
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_count", fifo_count, 0);
    rst = 0;
    prep();
    tick_period = 2;
    repeat (40) @(negedge clk);
    tick_period = 0;
    check("rst_idle_ticks", mon_q.size() >= 15, 1);
    foreach (mon_q[i]) check($sformatf("rst_idle[%0d]", i), {mon_q[i].tx, mon_q[i].busy}, 2'b10);
    repeat (3) @(negedge clk);

    prep();
    push_word(8'h81, "cont");
    add_frame(8'h81, PAR_NONE, 1'b0);
    exp_q.push_back(2'b10);
    run_and_check("cont", 1);
    if (mon_q.size() >= 11) check("cont_clocks", mon_q[10].cyc - mon_q[0].cyc, 10);

    for (int b = 0; b < 8; b++) begin
      prep();
      parity_mode = 2'($urandom_range(0, 3));
      stop2 = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom);
        push_word(d, "rand");
        add_frame(d, parity_mode, stop2);
      end
      exp_q.push_back(2'b10);
      run_and_check($sformatf("rand%0d", b), $urandom_range(1, 5));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
